soc_interrupt_dispatcher: RTL and testbench
===========================================

Name: soc_interrupt_dispatcher

Overview:
Sequences delivery of interrupts from the SoC interrupt controller to the CPU core. It does four things:
- samples the controller's priority-encoded irq/irq_id and presents one vector to the CPU with a valid/ack handshake;
- tracks the in-service vector until end-of-interrupt (EOI);
- generates the one-cycle int_clears pulses that drop the controller's latched bits;
- owns the enable mask, writable through a small register port.

Sits between soc_interrupt_controller (feeds its enabled_int/int_clears, consumes irq/irq_id) and the core's trap logic.

Parameters:
NUM_INT, 32, number of interrupt vectors (1..32); bits above NUM_INT-1 of every mask read 0, writes to them are ignored.
ENABLE_RESET, 32'h0, reset value of the enable mask.

Ports:
clk  in  1  system clock
res  in  1  synchronous active-high reset
irq  in  1  controller: some enabled latched interrupt present
irq_id  in  5  controller: highest-priority pending vector (0 = highest)
enabled_int  out  32  enable mask to controller
int_clears  out  32  one-cycle clear pulses to controller
cpu_irq_valid  out  1  vector offered to CPU
cpu_irq_id  out  5  offered vector
cpu_irq_ack  in  1  CPU accepts offered vector (handshake completes when valid&&ack)
cpu_eoi  in  1  CPU finished current handler (one-cycle pulse)
cfg_we  in  1  register write strobe
cfg_addr  in  2  register select
cfg_wdata  in  32  write data
cfg_rdata  out  32  read data, combinational from cfg_addr

Behaviour:
- Clock and reset: one clock `clk`; `res` is synchronous, active-high. All state updates on posedge `clk`.
- Reset values:
  - state IDLE; cpu_irq_valid=0, cpu_irq_id=0.
  - int_clears=0; enabled_int=ENABLE_RESET; in_service=0; eoi_err=0.
  - `res` mid-handshake aborts everything and drops valid the next edge.
- Registers:
  - addr0 ENABLE: rw.
  - addr1 CLEAR: write-1 bits pulse int_clears next cycle; reads 0.
  - addr2 STATUS: ro, {eoi_err[31], state[17:16], cur_id[12:8], in_service_lowest[4:0]}.
  - addr3 IN_SERVICE: ro mask; any write clears eoi_err.
- States and transitions:
  - IDLE: if irq, latch cur_id<=irq_id, set cpu_irq_valid, go OFFER. Latency irq->valid = 1 cycle.
  - OFFER:
    - valid stays high while waiting.
    - irq low: drop valid, return IDLE next cycle (vector disabled/cleared before ack).
    - irq_id changes without ack: update cur_id/cpu_irq_id the same edge; the higher-priority vector replaces the offer.
    - valid&&ack: next cycle int_clears[cur_id]=1 for exactly one cycle, set in_service[cur_id], drop valid, go SERVICE.
  - SERVICE: cpu_eoi clears in_service bit and goes IDLE next edge. irq is ignored in this state when the nesting feature is compiled out.
- Boundary cases:
  - cpu_eoi in IDLE/OFFER: ignored; sets sticky eoi_err.
  - cpu_irq_ack without valid: ignored.
  - CLEAR write and ack clear in the same cycle: int_clears is their bitwise OR.
  - ENABLE write takes effect next cycle. The controller updates irq combinationally; OFFER then follows the irq rules above.
  - int_clears is never asserted for more than 1 cycle per event.

Optional Feature:
SOC_INT_NESTING_EN
- Defined: in_service is a full mask (nesting depth up to NUM_INT).
  - In SERVICE, irq && irq_id < lowest set in_service bit -> offer (enter OFFER).
  - Ack pushes the new bit; irq dropping in OFFER returns to SERVICE if in_service!=0, else IDLE.
  - cpu_eoi clears the lowest set in_service bit; returns IDLE when the mask becomes 0, else stays SERVICE.
- Undefined: at most one bit set; no offers are made in SERVICE.

Decomposition:
- Package soc_int_pkg:
  - state enum (IDLE, OFFER, SERVICE; 2 bits);
  - register address constants;
  - INT_ID_W=5, MAX_INT=32;
  - STATUS field bit positions.
- One sub-module, soc_int_lowest_bit: parameterised find-first-set (mask -> valid, index). Used for in_service_lowest and for the nesting compare.

Test Plan:
- Reset, ENABLE=0x5, irq=1 id=2 -> valid=1 id=2 after 1 cycle; ack -> int_clears=0x4 one cycle, STATUS.state=SERVICE; eoi -> IDLE, IN_SERVICE=0.
- In OFFER with id=2, irq_id changes to 0 before ack -> cpu_irq_id=0 next cycle; ack -> int_clears=0x1.
- In OFFER, irq falls -> valid=0, IDLE next cycle, no int_clears pulse.
- CLEAR write 0x10 in the same cycle as ack of id 3 -> int_clears=0x18 for one cycle only.
- cpu_eoi in IDLE -> STATUS bit31=1; write to addr3 -> bit31=0. `res` asserted during OFFER -> valid=0 and ENABLE=ENABLE_RESET next edge.
- With SOC_INT_NESTING_EN: service id 4, then irq id 1 -> offered and acked, IN_SERVICE=0x12. eoi -> 0x10, state SERVICE. eoi -> 0, IDLE. Without the macro: id 1 is not offered until after the first eoi.

Source files
------------

// File: rtl/soc_int_pkg.sv
// soc_int_pkg: shared types, register map and STATUS layout for the interrupt dispatcher
package soc_int_pkg;
  localparam int INT_ID_W = 5;
  localparam int MAX_INT = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, OFFER = 2'd1, SERVICE = 2'd2} state_t;
  localparam logic [1:0] ADDR_ENABLE = 2'd0;
  localparam logic [1:0] ADDR_CLEAR = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_IN_SERVICE = 2'd3;
  localparam int STATUS_EOI_ERR = 31;
  localparam int STATUS_STATE_LSB = 16;
  localparam int STATUS_CUR_ID_LSB = 8;
  localparam int STATUS_LOWEST_LSB = 0;
endpackage

// File: rtl/soc_int_lowest_bit.sv
// soc_int_lowest_bit: find-first-set, lowest index (highest priority) wins
module soc_int_lowest_bit
  import soc_int_pkg::*;
#(
  parameter int W = MAX_INT,
  parameter int IW = INT_ID_W
) (
  input  logic [W-1:0]  mask,
  output logic          valid,
  output logic [IW-1:0] index
);
  assign valid = |mask;
  always_comb begin
    index = '0;
    for (int i = W - 1; i >= 0; i--) if (mask[i]) index = IW'(i);
  end
endmodule

// File: rtl/soc_interrupt_dispatcher.sv
// soc_interrupt_dispatcher: offers controller interrupts to the CPU, tracks EOI, owns the enable mask.
// Nested preemption is compiled in with SOC_INT_NESTING_EN.
module soc_interrupt_dispatcher
  import soc_int_pkg::*;
#(
  parameter int NUM_INT = 32,
  parameter logic [31:0] ENABLE_RESET = 32'h0
) (
  input  logic                clk,
  input  logic                res,
  input  logic                irq,
  input  logic [INT_ID_W-1:0] irq_id,
  output logic [31:0]         enabled_int,
  output logic [31:0]         int_clears,
  output logic                cpu_irq_valid,
  output logic [INT_ID_W-1:0] cpu_irq_id,
  input  logic                cpu_irq_ack,
  input  logic                cpu_eoi,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_addr,
  input  logic [31:0]         cfg_wdata,
  output logic [31:0]         cfg_rdata
);
  localparam logic [31:0] VALID_MASK = NUM_INT >= 32 ? 32'hFFFF_FFFF : 32'((64'd1 << NUM_INT) - 64'd1);
  state_t state;
  logic [INT_ID_W-1:0] cur_id, lowest;
  logic [31:0] in_service, cur_bit, eoi_mask, clear_wr, status;
  logic lowest_valid, eoi_err, ack_fire, nest_offer;
  soc_int_lowest_bit #(.W(MAX_INT), .IW(INT_ID_W)) u_lowest (
    .mask(in_service),
    .valid(lowest_valid),
    .index(lowest)
  );
  assign cpu_irq_id = cur_id;
  assign ack_fire = cpu_irq_valid && cpu_irq_ack;
  assign cur_bit = VALID_MASK & (32'd1 << cur_id);
  assign eoi_mask = in_service & ~(32'd1 << lowest);
  assign clear_wr = (cfg_we && cfg_addr == ADDR_CLEAR) ? (cfg_wdata & VALID_MASK) : 32'd0;
`ifdef SOC_INT_NESTING_EN
  assign nest_offer = irq && (!lowest_valid || irq_id < lowest);
`else
  assign nest_offer = 1'b0;
`endif
  assign status = {eoi_err, 13'd0, state, 3'd0, cur_id, 3'd0, lowest};
  assign cfg_rdata = cfg_addr == ADDR_ENABLE ? enabled_int :
                     cfg_addr == ADDR_STATUS ? status :
                     cfg_addr == ADDR_IN_SERVICE ? in_service : 32'd0;
  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
      cur_id <= '0;
      cpu_irq_valid <= 1'b0;
      int_clears <= '0;
      enabled_int <= ENABLE_RESET & VALID_MASK;
      in_service <= '0;
      eoi_err <= 1'b0;
    end else begin
      int_clears <= clear_wr | (ack_fire ? cur_bit : 32'd0);
      if (cfg_we && cfg_addr == ADDR_ENABLE) enabled_int <= cfg_wdata & VALID_MASK;
      eoi_err <= (eoi_err && !(cfg_we && cfg_addr == ADDR_IN_SERVICE)) || (cpu_eoi && state != SERVICE);
      case (state)
        IDLE: if (irq) begin
          cur_id <= irq_id;
          cpu_irq_valid <= 1'b1;
          state <= OFFER;
        end
        OFFER: if (ack_fire) begin
          in_service <= in_service | cur_bit;
          cpu_irq_valid <= 1'b0;
          state <= SERVICE;
        end else if (!irq) begin
          cpu_irq_valid <= 1'b0;
          state <= lowest_valid ? SERVICE : IDLE;
        end else cur_id <= irq_id;
        SERVICE: if (cpu_eoi) begin
          in_service <= eoi_mask;
          state <= |eoi_mask ? SERVICE : IDLE;
        end else if (nest_offer) begin
          cur_id <= irq_id;
          cpu_irq_valid <= 1'b1;
          state <= OFFER;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_soc_interrupt_dispatcher.sv
// tb_soc_interrupt_dispatcher: scoreboard bench; expectations queued with stimulus, drained after each edge
`timescale 1ns/100ps
module tb_soc_interrupt_dispatcher;
  logic clk = 0, res = 1, irq = 0, cpu_irq_ack = 0, cpu_eoi = 0, cfg_we = 0;
  logic [4:0] irq_id = 0, cpu_irq_id;
  logic [1:0] cfg_addr = 0;
  logic [31:0] cfg_wdata = 0, enabled_int, int_clears, cfg_rdata;
  logic cpu_irq_valid;
  int n_cmp = 0, n_bad = 0;
  typedef struct {string tag; int sig; logic [1:0] addr; logic [31:0] val;} exp_t;
  exp_t q[$];
  soc_interrupt_dispatcher dut (
    .clk(clk), .res(res), .irq(irq), .irq_id(irq_id), .enabled_int(enabled_int),
    .int_clears(int_clears), .cpu_irq_valid(cpu_irq_valid), .cpu_irq_id(cpu_irq_id),
    .cpu_irq_ack(cpu_irq_ack), .cpu_eoi(cpu_eoi), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
  );
  always #10 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask
  task automatic push(input string tag, input int sig, input logic [1:0] addr, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.sig = sig; e.addr = addr; e.val = val;
    q.push_back(e);
  endtask
  task automatic ev(input string tag, input logic [31:0] val); push(tag, 0, 0, val); endtask
  task automatic eid(input string tag, input logic [31:0] val); push(tag, 1, 0, val); endtask
  task automatic ecl(input string tag, input logic [31:0] val); push(tag, 2, 0, val); endtask
  task automatic erd(input string tag, input logic [1:0] a, input logic [31:0] val); push(tag, 3, a, val); endtask
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cfg_we = 0; cpu_irq_ack = 0; cpu_eoi = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.sig == 0) check(e.tag, {31'd0, cpu_irq_valid}, e.val);
      else if (e.sig == 1) check(e.tag, {27'd0, cpu_irq_id}, e.val);
      else if (e.sig == 2) check(e.tag, int_clears, e.val);
      else begin
        cfg_addr = e.addr;
        #1;
        check(e.tag, cfg_rdata, e.val);
      end
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
  endtask
  initial begin
    ev("rst_valid", 0); ecl("rst_clears", 0); erd("rst_enable", 0, 0); erd("rst_status", 2, 0); erd("rst_insvc", 3, 0);
    step();
    res = 0;
    wr(0, 32'h5); erd("enable_wr", 0, 32'h5); step();
    irq = 1; irq_id = 2; ev("offer_valid", 1); eid("offer_id", 2); erd("offer_status", 2, 32'h0001_0200); step();
    ev("offer_hold", 1); ecl("offer_noclr", 0); step();
    cpu_irq_ack = 1; ev("ack_valid", 0); ecl("ack_clr", 32'h4); erd("ack_status", 2, 32'h0002_0202); erd("ack_insvc", 3, 32'h4); step();
    irq = 0; ecl("clr_once", 0); erd("svc_status", 2, 32'h0002_0202); step();
    cpu_eoi = 1; erd("eoi_insvc", 3, 0); erd("eoi_status", 2, 32'h0000_0200); step();
    irq = 1; irq_id = 2; ev("pre_valid", 1); eid("pre_id2", 2); step();
    irq_id = 0; ev("pre_valid2", 1); eid("pre_id0", 0); step();
    cpu_irq_ack = 1; ecl("pre_clr", 32'h1); erd("pre_insvc", 3, 32'h1); step();
    irq = 0; cpu_eoi = 1; erd("pre_eoi", 3, 0); step();
    irq = 1; irq_id = 2; ev("drop_offer", 1); step();
    irq = 0; ev("drop_valid", 0); ecl("drop_noclr", 0); erd("drop_status", 2, 32'h0000_0200); step();
    ecl("drop_noclr2", 0); ev("drop_idle", 0); step();
    irq = 1; irq_id = 3; ev("or_offer", 1); eid("or_id", 3); step();
    cpu_irq_ack = 1; wr(1, 32'h10); ecl("or_clr", 32'h18); erd("clear_rd", 1, 0); step();
    irq = 0; ecl("or_once", 0); step();
    cpu_eoi = 1; erd("or_eoi", 3, 0); step();
    cpu_eoi = 1; erd("eoi_err_set", 2, 32'h8000_0300); step();
    wr(3, 32'h0); erd("eoi_err_clr", 2, 32'h0000_0300); step();
    cpu_irq_ack = 1; ev("ack_novalid", 0); ecl("ack_noclr", 0); step();
    wr(0, 32'hFF); erd("enable_ff", 0, 32'hFF); step();
    irq = 1; irq_id = 1; ev("rst_offer", 1); step();
    res = 1; ev("rst_mid_valid", 0); erd("rst_mid_enable", 0, 0); erd("rst_mid_status", 2, 0); step();
    res = 0; irq = 0; step();
    irq = 1; irq_id = 4; ev("nest_offer4", 1); eid("nest_id4", 4); step();
    cpu_irq_ack = 1; ecl("nest_clr4", 32'h10); erd("nest_insvc4", 3, 32'h10); step();
    irq_id = 1;
`ifdef SOC_INT_NESTING_EN
    ev("nest_offer1", 1); eid("nest_id1", 1); step();
    cpu_irq_ack = 1; ecl("nest_clr1", 32'h2); erd("nest_insvc12", 3, 32'h12); step();
    irq = 0; cpu_eoi = 1; erd("nest_eoi1", 3, 32'h10); erd("nest_eoi1_st", 2, 32'h0002_0104); step();
    cpu_eoi = 1; erd("nest_eoi2", 3, 0); erd("nest_eoi2_st", 2, 32'h0000_0100); step();
`else
    ev("nonest_hold", 0); erd("nonest_st", 2, 32'h0002_0404); step();
    ev("nonest_hold2", 0); step();
    cpu_eoi = 1; erd("nonest_eoi", 3, 0); erd("nonest_eoi_st", 2, 32'h0000_0400); step();
    ev("nonest_offer1", 1); eid("nonest_id1", 1); step();
    cpu_irq_ack = 1; ecl("nonest_clr1", 32'h2); erd("nonest_insvc", 3, 32'h2); step();
    irq = 0; cpu_eoi = 1; erd("nonest_eoi2", 3, 0); step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
